// File: rtl/seq_code_checker_if.sv
// Sample stream into the sequence-code checker and its status/decoded outputs.
// The master drives the code samples; the checker is the slave.
interface seq_code_checker_if #(
    parameter int ERR_WIDTH = 8
);
    logic [2:0]           code_in;
    logic                 code_valid;
    logic                 err_clr;
    logic [1:0]           index;
    logic                 index_valid;
    logic                 seq_err;
    logic                 illegal_code;
    logic                 locked;
    logic [ERR_WIDTH-1:0] err_count;

    modport master (
        output code_in, code_valid, err_clr,
        input  index, index_valid, seq_err, illegal_code, locked, err_count
    );

    modport slave (
        input  code_in, code_valid, err_clr,
        output index, index_valid, seq_err, illegal_code, locked, err_count
    );
endinterface

// File: rtl/seq_code_checker.sv
// Receive-side checker for the 000->011->101->110 counter sequence.
// It decodes samples, tracks successor legality, acquires/holds lock and counts errors.
module seq_code_checker #(
    parameter int LOCK_COUNT  = 4,
    parameter int UNLOCK_ERRS = 2,
    parameter int ERR_WIDTH   = 8
) (
    input  logic              clk,
    input  logic              reset,
    seq_code_checker_if.slave bus
);

    typedef enum logic [1:0] {
        HUNT   = 2'b00,
        VERIFY = 2'b01,
        LOCKED = 2'b10,
        UNUSED = 2'b11
    } state_e;

    localparam logic [3:0] LOCK_CNT   = 4'(LOCK_COUNT);
    localparam logic [1:0] UNLOCK_CNT = 2'(UNLOCK_ERRS);

    function automatic logic [1:0] ordinal(input logic [2:0] c);
        case (c)
            3'b011:  ordinal = 2'd1;
            3'b101:  ordinal = 2'd2;
            3'b110:  ordinal = 2'd3;
            default: ordinal = 2'd0;
        endcase
    endfunction

    function automatic logic [2:0] next_code(input logic [2:0] c);
        case (ordinal(c))
            2'd0:    next_code = 3'b011;
            2'd1:    next_code = 3'b101;
            2'd2:    next_code = 3'b110;
            default: next_code = 3'b000;
        endcase
    endfunction

    state_e               state_q, state_d;
    logic [3:0]           run_q, run_d;
    logic [1:0]           miss_q, miss_d;
    logic [2:0]           prev_q, prev_d;
    logic [1:0]           index_q, index_d;
    logic                 index_valid_q, index_valid_d;
    logic                 seq_err_q, seq_err_d;
    logic                 illegal_q, illegal_d;
    logic [ERR_WIDTH-1:0] err_count_q, err_count_d;

    logic legal;
    logic succ;
    logic err_evt;

    // Exactly the four sequence codes have even parity.
    assign legal   = ~^bus.code_in;
    assign succ    = (bus.code_in == next_code(prev_q));
    assign err_evt = seq_err_d | illegal_d;

    // NOTE: every signal gets a default before any branch, so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        run_d         = run_q;
        miss_d        = miss_q;
        prev_d        = prev_q;
        index_d       = index_q;
        index_valid_d = 1'b0;
        seq_err_d     = 1'b0;
        illegal_d     = 1'b0;
        err_count_d   = err_count_q;

        if (bus.code_valid) begin
            if (legal) begin
                index_valid_d = 1'b1;
                index_d       = ordinal(bus.code_in);
            end

            case (state_q)
                HUNT: begin
                    if (legal) begin
                        prev_d  = bus.code_in;
                        run_d   = 4'd0;
                        state_d = VERIFY;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
                VERIFY: begin
                    if (!legal) begin
                        illegal_d = 1'b1;
                        state_d   = HUNT;
                    end else if (succ) begin
                        prev_d = bus.code_in;
                        run_d  = run_q + 4'd1;
                        if (run_d == LOCK_CNT) begin
                            state_d = LOCKED;
                            miss_d  = 2'd0;
                        end
                    end else begin
                        seq_err_d = 1'b1;
                        run_d     = 4'd0;
                        prev_d    = bus.code_in;
                    end
                end
                LOCKED: begin
                    if (!legal) begin
                        // Flywheel: assume the far counter kept stepping.
                        illegal_d = 1'b1;
                        miss_d    = miss_q + 2'd1;
                        prev_d    = next_code(prev_q);
                    end else if (succ) begin
                        miss_d = 2'd0;
                        prev_d = bus.code_in;
                    end else begin
                        seq_err_d = 1'b1;
                        miss_d    = miss_q + 2'd1;
                        prev_d    = bus.code_in;
                    end
                    if (miss_d == UNLOCK_CNT) begin
                        state_d = HUNT;
                        run_d   = 4'd0;
                        miss_d  = 2'd0;
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        if (state_q == UNUSED) begin
            state_d = HUNT;
        end

        if (bus.err_clr) begin
            err_count_d = err_evt ? ERR_WIDTH'(1) : '0;
        end else if (err_evt && (err_count_q != '1)) begin
            err_count_d = err_count_q + ERR_WIDTH'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= HUNT;
            run_q         <= 4'd0;
            miss_q        <= 2'd0;
            prev_q        <= 3'b000;
            index_q       <= 2'd0;
            index_valid_q <= 1'b0;
            seq_err_q     <= 1'b0;
            illegal_q     <= 1'b0;
            err_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            run_q         <= run_d;
            miss_q        <= miss_d;
            prev_q        <= prev_d;
            index_q       <= index_d;
            index_valid_q <= index_valid_d;
            seq_err_q     <= seq_err_d;
            illegal_q     <= illegal_d;
            err_count_q   <= err_count_d;
        end
    end

    assign bus.index        = index_q;
    assign bus.index_valid  = index_valid_q;
    assign bus.seq_err      = seq_err_q;
    assign bus.illegal_code = illegal_q;
    assign bus.locked       = (state_q == LOCKED);
    assign bus.err_count    = err_count_q;

endmodule

// File: tb/tb_seq_code_checker.sv
// Directed bench for seq_code_checker: lock acquisition, errors, flywheel,
// code_valid gaps, counter saturation/clear and reset while locked.
module tb_seq_code_checker;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    seq_code_checker_if #(.ERR_WIDTH(8)) bus ();

    seq_code_checker #(
        .LOCK_COUNT (4),
        .UNLOCK_ERRS(2),
        .ERR_WIDTH  (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Applies one sample and waits until just after the capturing edge.
    task automatic step(input logic v, input logic [2:0] c, input logic clr);
        bus.code_valid = v;
        bus.code_in    = c;
        bus.err_clr    = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input int idx, input int iv, input int se,
                             input int ic, input int lk, input int ec);
        check({tag, ".index"},        32'(bus.index),        32'(idx));
        check({tag, ".index_valid"},  32'(bus.index_valid),  32'(iv));
        check({tag, ".seq_err"},      32'(bus.seq_err),      32'(se));
        check({tag, ".illegal_code"}, 32'(bus.illegal_code), 32'(ic));
        check({tag, ".locked"},       32'(bus.locked),       32'(lk));
        check({tag, ".err_count"},    32'(bus.err_count),    32'(ec));
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        bus.code_valid = 1'b0;
        bus.code_in    = 3'b000;
        bus.err_clr    = 1'b0;

        // Reset has priority over a valid legal sample.
        reset = 1'b1;
        step(1, 3'b011, 0);
        step(1, 3'b011, 0);
        check_all("reset", 0, 0, 0, 0, 0, 0);
        reset = 1'b0;

        // Acquire lock: HUNT entry plus four correct transitions.
        step(1, 3'b000, 0); check_all("acq0", 0, 1, 0, 0, 0, 0);
        step(1, 3'b011, 0); check_all("acq1", 1, 1, 0, 0, 0, 0);
        step(1, 3'b101, 0); check_all("acq2", 2, 1, 0, 0, 0, 0);
        step(1, 3'b110, 0); check_all("acq3", 3, 1, 0, 0, 0, 0);
        step(1, 3'b000, 0); check_all("acq4", 0, 1, 0, 0, 1, 0);

        // Wrong successor while locked: one miss, then resync on 101's successor.
        step(1, 3'b101, 0); check_all("wrong", 2, 1, 1, 0, 1, 1);
        step(1, 3'b110, 0); check_all("resync1", 3, 1, 0, 0, 1, 1);
        step(1, 3'b000, 0); check_all("resync2", 0, 1, 0, 0, 1, 1);

        // err_clr alone clears the counter.
        step(0, 3'b000, 1); check_all("clr_idle", 0, 0, 0, 0, 1, 0);

        // Two illegal codes drop lock on the second.
        step(1, 3'b111, 0); check_all("ill1", 0, 0, 0, 1, 1, 1);
        step(1, 3'b010, 0); check_all("ill2", 0, 0, 0, 1, 0, 2);

        // Repeat in VERIFY resets run; four further transitions needed.
        step(1, 3'b011, 0); check_all("ver0", 1, 1, 0, 0, 0, 2);
        step(1, 3'b011, 0); check_all("stall", 1, 1, 1, 0, 0, 3);
        step(1, 3'b101, 0); check_all("ver1", 2, 1, 0, 0, 0, 3);
        step(1, 3'b110, 0); check_all("ver2", 3, 1, 0, 0, 0, 3);
        step(1, 3'b000, 0); check_all("ver3", 0, 1, 0, 0, 0, 3);
        step(1, 3'b011, 0); check_all("ver4", 1, 1, 0, 0, 1, 3);

        // code_valid low with junk: nothing moves.
        step(0, 3'b111, 0); check_all("gap1", 1, 0, 0, 0, 1, 3);
        step(0, 3'b010, 0); check_all("gap2", 1, 0, 0, 0, 1, 3);
        step(0, 3'b000, 0); check_all("gap3", 1, 0, 0, 0, 1, 3);
        step(1, 3'b101, 0); check_all("resume", 2, 1, 0, 0, 1, 3);

        // 300 illegal samples: unlock after two, saturate at 255 after 252.
        for (int k = 1; k <= 300; k++) begin
            step(1, 3'b111, 0);
            if (k == 2)   check_all("sat_unlock", 2, 0, 0, 1, 0, 5);
            if (k == 251) check("sat_254", 32'(bus.err_count), 32'd254);
            if (k == 252) check("sat_255", 32'(bus.err_count), 32'd255);
        end
        check_all("sat_end", 2, 0, 0, 1, 0, 255);

        step(1, 3'b111, 1); check_all("clr_err", 2, 0, 0, 1, 0, 1);
        step(0, 3'b000, 1); check_all("clr_only", 2, 0, 0, 0, 0, 0);

        // Relock, then reset while LOCKED.
        step(1, 3'b000, 0);
        step(1, 3'b011, 0);
        step(1, 3'b101, 0);
        step(1, 3'b110, 0);
        step(1, 3'b111, 0); check_all("relock_ill", 3, 0, 0, 1, 0, 1);
        step(1, 3'b000, 0);
        step(1, 3'b011, 0);
        step(1, 3'b101, 0);
        step(1, 3'b110, 0);
        step(1, 3'b000, 0); check_all("relock", 0, 1, 0, 0, 1, 1);
        reset = 1'b1;
        step(1, 3'b011, 0); check_all("reset_locked", 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        step(0, 3'b000, 0); check_all("post_reset", 0, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_code_checker.md
Name: seq_code_checker

Overview:
- Receive-side checker for the 3-bit custom-sequence counter. That counter is built from T flip-flops and steps 000 -> 011 -> 101 -> 110 -> 000.
- Samples the code stream from a counter on another board or another clock-enabled path and decodes each code to its ordinal.
- Verifies that every sample is the legal successor of the previous one, acquires and holds lock, and counts errors for the lab display/LEDs.

Parameters:
- LOCK_COUNT, 4: consecutive correct transitions required to enter LOCKED (legal range 1..15).
- UNLOCK_ERRS, 2: consecutive bad samples while LOCKED that drop lock (legal range 1..3).
- ERR_WIDTH, 8: width of the saturating error counter.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- code_in  in  3  sampled counter code, q[2:0].
- code_valid  in  1  code_in is sampled this cycle only when this is high.
- err_clr  in  1  synchronous clear of err_count.
- index  out  2  decoded ordinal of the last legal sample.
- index_valid  out  1  one-cycle pulse: index updated.
- seq_err  out  1  one-cycle pulse: legal code but wrong successor.
- illegal_code  out  1  one-cycle pulse: code not in the sequence.
- locked  out  1  high while the FSM is in LOCKED.
- err_count  out  ERR_WIDTH  saturating count of seq_err plus illegal_code events.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port reset.
- Reset: at a rising clk edge with reset=1, state=HUNT, run=0, miss=0, prev=000, and every output is 0. Reset mid-stream discards all history; reset has priority over all other inputs.
- Decode (legal codes all have even parity):
  - 000 -> 0, 011 -> 1, 101 -> 2, 110 -> 3.
  - 001, 010, 100, 111 are illegal.
- Successor function: next(prev) = code of (ordinal(prev)+1) mod 4, so 110 wraps to 000.
- Latency: every output is registered and reflects the sample taken on the previous edge. With code_valid=0, state, prev, index and counters hold and all pulses are 0.
- index_valid: pulses on every valid legal sample, in any state; index is updated on the same edge.
- HUNT:
  - Legal sample: prev <= code, run <= 0, go to VERIFY.
  - Illegal sample: pulse illegal_code, stay in HUNT.
  - seq_err never fires in HUNT.
- VERIFY:
  - code == next(prev): run++. When run reaches LOCK_COUNT, go to LOCKED and assert locked on that same edge; miss <= 0.
  - Legal code but wrong successor (including a repeat of prev, i.e. a stalled counter): pulse seq_err, run <= 0, prev <= code, stay in VERIFY.
  - Illegal sample: pulse illegal_code, go to HUNT.
- LOCKED:
  - Correct successor: miss <= 0, prev <= code.
  - Wrong legal code: pulse seq_err, miss++, prev <= code.
  - Illegal code: pulse illegal_code, miss++, prev <= next(prev) (flywheel).
  - When miss reaches UNLOCK_ERRS: go to HUNT, locked falls on the same edge, run <= 0.
- err_count:
  - Increments by 1 on each seq_err or illegal_code pulse. The two pulses are mutually exclusive.
  - Saturates at all-ones.
  - err_clr with no error on the same edge: count <= 0.
  - err_clr together with an error on the same edge: count <= 1.
- The FSM encoding is 2-bit; the unused encoding returns to HUNT on the next edge.

Test Plan:
- Reset, then valid samples 000,011,101,110,000 on consecutive cycles -> index_valid pulses each cycle with index 0,1,2,3,0. locked rises on the edge after the 5th sample. err_count=0.
- After lock, inject 101 where 011 is expected, then continue 110,000 -> one seq_err pulse, err_count=1. locked stays high (miss=1<2), then miss clears.
- After lock, send 111 then 010 -> two illegal_code pulses. locked falls on the edge after 010, state=HUNT, err_count=2. index_valid does not pulse for these samples.
- In VERIFY, repeat 011,011 -> seq_err on the second sample, run resets. Lock then needs 4 further correct transitions.
- Toggle code_valid low for 3 cycles mid-sequence with junk on code_in -> no pulses, no state change. The sequence then resumes correctly.
- Drive 300 illegal samples with ERR_WIDTH=8 -> err_count saturates at 255. Then assert err_clr together with an illegal sample -> err_count=1. Then err_clr alone -> err_count=0. Assert reset while LOCKED -> all outputs 0 on the next edge.
